instr_fetch_queue: RTL and testbench

//  Fetch stage directly downstream of the PC register/mem_addr_sel stage.

---
 rtl/instr_fetch_queue.sv | 106 ++++++++++
 tb/tb_instr_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: issues in-order word fetches for the current pc and queues {pc, instr} for decode
`ifndef REG_LEN
`define REG_LEN 32
`endif

module instr_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int REG_LEN = `REG_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_LEN-1:0] pc,
    input  logic               flush,
    output logic               pc_advance,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [REG_LEN-1:0] mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [REG_LEN-1:0] mem_rsp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [REG_LEN-1:0] out_instr,
    output logic [REG_LEN-1:0] out_pc,
    output logic               out_misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CREDITS = DEPTH[CW:0];

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             state;
    logic [CW-1:0]      count, inflight, stale, stale_next;
    logic [AW-1:0]      wr_ptr, rd_ptr, pq_wr, pq_rd;
    logic [REG_LEN-1:0] pq [DEPTH];
    logic [REG_LEN-1:0] fifo_pc [DEPTH];
    logic [REG_LEN-1:0] fifo_instr [DEPTH];
    logic               fifo_mis [DEPTH];
    logic               accept, rsp_hit, push, pop;

    assign mem_req_valid = !rst && state == RUN && !flush &&
                           ({1'b0, count} + {1'b0, inflight} < CREDITS);
    assign accept        = mem_req_valid && mem_req_ready;
    assign pc_advance    = accept;
    assign mem_req_addr  = mem_req_valid ? {pc[REG_LEN-1:2], 2'b00} : '0;
    assign rsp_hit       = mem_rsp_valid && inflight != '0;
    assign push          = !rst && !flush && state == RUN && rsp_hit;
    assign out_valid     = count != '0 && !flush;
    assign pop           = out_valid && out_ready;
    assign out_pc        = out_valid ? fifo_pc[rd_ptr] : '0;
    assign out_instr     = out_valid ? fifo_instr[rd_ptr] : '0;
    assign out_misalign  = out_valid && fifo_mis[rd_ptr];
    assign stale_next    = inflight - CW'(rsp_hit);

    // Control: occupancy, request credits, drain bookkeeping and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            count    <= '0;
            inflight <= '0;
            stale    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pq_wr    <= '0;
            pq_rd    <= '0;
        end else if (flush) begin
            state    <= stale_next != '0 ? DRAIN : RUN;
            count    <= '0;
            inflight <= stale_next;
            stale    <= stale_next;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pq_wr    <= '0;
            pq_rd    <= '0;
        end else if (state == DRAIN) begin
            if (rsp_hit) begin
                stale    <= stale - 1'b1;
                inflight <= inflight - 1'b1;
                state    <= stale == CW'(1) ? RUN : DRAIN;
            end
        end else begin
            count    <= count + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(accept) - CW'(rsp_hit);
            if (accept) pq_wr <= pq_wr + AW'(1);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                pq_rd  <= pq_rd + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Storage: pending pcs and FIFO payload, written only while running
    always_ff @(posedge clk) begin
        if (accept) pq[pq_wr] <= pc;
        if (push) begin
            fifo_pc[wr_ptr]    <= pq[pq_rd];
            fifo_instr[wr_ptr] <= mem_rsp_data;
            fifo_mis[wr_ptr]   <= pq[pq_rd][1:0] != 2'b00;
        end
    end

    // A response with nothing in flight is a memory protocol violation and is otherwise ignored
    ap_rsp_in_flight: assert property (@(posedge clk) disable iff (rst) mem_rsp_valid |-> inflight != '0);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed tests with a queue-level reference model checked every cycle
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, mem_req_ready, mem_rsp_valid, out_ready;
    logic [31:0] pc, mem_rsp_data;
    logic        pc_advance, mem_req_valid, out_valid, out_misalign;
    logic [31:0] mem_req_addr, out_instr, out_pc;

    instr_fetch_queue #(.DEPTH(DEPTH), .REG_LEN(32)) dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_advance(pc_advance),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { int due; logic [31:0] addr; } req_t;

    logic [31:0] pend[$];
    ent_t        fq[$];
    req_t        rq[$];
    int          stale_m = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          model_ok = 1'b0;
    logic        obs_rv, obs_adv, obs_ov, obs_mis;
    logic [31:0] obs_addr, obs_opc, obs_instr;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // One clock cycle: compare against the model, record, advance model, memory and upstream pc
    task automatic step();
        logic e_req, e_ov;
        bit   do_pop;
        int   n;
        @(negedge clk);
        e_req = !rst && stale_m == 0 && !flush && (fq.size() + pend.size() < DEPTH);
        e_ov  = fq.size() != 0 && !flush;
        if (model_ok) begin
            check("m_req_valid", mem_req_valid, e_req);
            check("m_pc_advance", pc_advance, e_req && mem_req_ready);
            if (e_req) check("m_req_addr", mem_req_addr, {pc[31:2], 2'b00});
            check("m_out_valid", out_valid, e_ov);
            if (e_ov) begin
                check("m_out_pc", out_pc, fq[0].pc);
                check("m_out_instr", out_instr, fq[0].data);
                check("m_out_misalign", out_misalign, fq[0].pc[1:0] != 2'b00);
            end
        end
        obs_rv = mem_req_valid; obs_adv = pc_advance; obs_addr = mem_req_addr;
        obs_ov = out_valid; obs_opc = out_pc; obs_instr = out_instr; obs_mis = out_misalign;
        if (mem_req_valid && mem_req_ready) begin
            n = cyc + lat;
            if (rq.size() != 0 && n <= rq[$].due) n = rq[$].due + 1;
            rq.push_back('{n, mem_req_addr});
        end
        if (rst) begin
            pend.delete(); fq.delete(); stale_m = 0; model_ok = 1'b1;
        end else if (flush) begin
            n = pend.size() + stale_m;
            stale_m = (mem_rsp_valid && n > 0) ? n - 1 : n;
            pend.delete(); fq.delete();
        end else begin
            do_pop = fq.size() != 0 && out_ready;
            if (mem_rsp_valid) begin
                if (stale_m > 0) stale_m--;
                else if (pend.size() != 0) begin
                    fq.push_back('{pend[0], mem_rsp_data});
                    void'(pend.pop_front());
                end
            end
            if (do_pop) void'(fq.pop_front());
            if (e_req && mem_req_ready) pend.push_back(pc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (obs_adv) pc = pc + 32'd4;
        if (rq.size() != 0 && rq[0].due == cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = rq[0].addr ^ 32'hDEAD_0000;
            void'(rq.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0;
        rq.delete(); mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_valid"}, obs_rv, 0);
        check({tag, "_pc_advance"}, obs_adv, 0);
        check({tag, "_req_addr"}, obs_addr, 0);
        check({tag, "_out_valid"}, obs_ov, 0);
        check({tag, "_out_pc"}, obs_opc, 0);
        check({tag, "_out_instr"}, obs_instr, 0);
        check({tag, "_out_misalign"}, obs_mis, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] t1_pc [3];
        logic [31:0] t1_in [3];
        logic        pv, pr;
        logic [31:0] pa;
        int          na, nd;
        t1_pc = '{32'h0, 32'h4, 32'h8};
        t1_in = '{32'hDEAD_0000, 32'hDEAD_0004, 32'hDEAD_0008};
        rst = 1'b1; flush = 1'b0; pc = 32'h44; mem_req_ready = 1'b1; out_ready = 1'b1;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;

        do_reset();
        check_zero("rst");

        pc = 32'h0;
        step();
        check("t1_first_adv", obs_adv, 1);
        check("t1_first_addr", obs_addr, 32'h0);
        check("t1_ov_c0", obs_ov, 0);
        step();
        check("t1_ov_c1", obs_ov, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t1_ov", obs_ov, 1);
            check("t1_pc", obs_opc, t1_pc[k]);
            check("t1_instr", obs_instr, t1_in[k]);
        end

        do_reset();
        pc = 32'h0; out_ready = 1'b0; lat = 1;
        na = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_adv) na++;
        end
        check("t2_accepts", na, 4);
        check("t2_full_req_valid", obs_rv, 0);
        check("t2_full_adv", obs_adv, 0);
        check("t2_head_valid", obs_ov, 1);
        check("t2_head_pc", obs_opc, 32'h0);
        out_ready = 1'b1;
        step();
        check("t2_pop_cycle_req", obs_rv, 0);
        step();
        check("t2_after_pop_req", obs_rv, 1);
        check("t2_after_pop_addr", obs_addr, 32'h10);

        do_reset();
        pc = 32'h0; out_ready = 1'b1; lat = 4;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_accept", obs_adv, 1);
        end
        flush = 1'b1; pc = 32'h100;
        step();
        check("t3_flush_ov", obs_ov, 0);
        check("t3_flush_req", obs_rv, 0);
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_drain_req", obs_rv, 0);
        end
        step();
        check("t3_resume_req", obs_rv, 1);
        check("t3_resume_addr", obs_addr, 32'h100);
        for (int k = 0; k < 10 && !obs_ov; k++) step();
        check("t3_out_valid", obs_ov, 1);
        check("t3_out_pc", obs_opc, 32'h100);
        check("t3_out_instr", obs_instr, 32'hDEAD_0100);

        do_reset();
        pc = 32'h0; out_ready = 1'b0; lat = 1;
        step(); step(); step();
        flush = 1'b1; out_ready = 1'b1; pc = 32'h200;
        step();
        check("t4_flush_ov", obs_ov, 0);
        check("t4_flush_req", obs_rv, 0);
        flush = 1'b0;
        step();
        check("t4_next_ov", obs_ov, 0);
        check("t4_next_req", obs_rv, 1);
        check("t4_next_addr", obs_addr, 32'h200);
        step();
        check("t4_empty_ov", obs_ov, 0);
        step();
        check("t4_first_ov", obs_ov, 1);
        check("t4_first_pc", obs_opc, 32'h200);

        do_reset();
        pc = 32'h0; out_ready = 1'b1; lat = 2;
        nd = 0; pv = 1'b0; pr = 1'b0; pa = 32'h0;
        for (int k = 0; k < 24; k++) begin
            mem_req_ready = (k % 2) == 1;
            step();
            if (pv && !pr) begin
                check("t5_stall_valid", obs_rv, 1);
                check("t5_stall_addr", obs_addr, pa);
            end
            if (obs_ov) begin
                check("t5_order_pc", obs_opc, nd * 4);
                nd++;
            end
            pv = obs_rv; pr = mem_req_ready; pa = obs_addr;
        end
        check("t5_delivered", nd, 10);
        mem_req_ready = 1'b1;

        do_reset();
        pc = 32'h102; out_ready = 1'b0; lat = 1;
        step();
        check("t6_req_valid", obs_rv, 1);
        check("t6_aligned_addr", obs_addr, 32'h100);
        step();
        step();
        check("t6_ov", obs_ov, 1);
        check("t6_out_pc", obs_opc, 32'h102);
        check("t6_misalign", obs_mis, 1);
        check("t6_instr", obs_instr, 32'hDEAD_0100);

        do_reset();
        pc = 32'h0; out_ready = 1'b1; lat = 4;
        step(); step();
        flush = 1'b1; pc = 32'h300;
        step();
        flush = 1'b0;
        step();
        check("t6_drain_req", obs_rv, 0);
        do_reset();
        check_zero("t6_rst");
        step();
        check("t6_post_rst_req", obs_rv, 1);
        check("t6_post_rst_addr", obs_addr, 32'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
